// File: rtl/mmcm_ps_pkg.sv
// Shared types and constants for the MMCM dynamic phase-shift initiator.
// The psdone latency constant describes the MMCM and is used only by benches.
package mmcm_ps_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } ps_state_e;

  localparam int DEF_PERIOD_STEPS = 1120;
  localparam int DEF_TIMEOUT_CYC  = 64;
  localparam int PSDONE_LATENCY   = 12;

endpackage

// File: rtl/ps_pos_counter.sv
// Modulo-PERIOD_STEPS up/down phase-position counter.
// A synchronous clear takes priority over a step.
module ps_pos_counter #(
  parameter int POS_W        = 16,
  parameter int PERIOD_STEPS = 1120
) (
  input  logic             psclk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             step_en,
  input  logic             up,
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W-1:0] LAST = POS_W'(PERIOD_STEPS - 1);

  always_ff @(posedge psclk or negedge reset_n) begin
    if (!reset_n) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (step_en) begin
      if (up) begin
        pos <= (pos == LAST) ? '0 : pos + POS_W'(1);
      end else begin
        pos <= (pos == '0) ? LAST : pos - POS_W'(1);
      end
    end
  end

endmodule

// File: rtl/mmcm_ps_ctrl.sv
// MMCM phase-shift initiator: issues one psen per requested step, waits for
// psdone each time, tracks absolute phase and aborts on timeout or unlock.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a command; pos_clr honoured here
// ST_ISSUE  | psen high this cycle (if locked), timeout counter cleared
// ST_WAIT   | one step outstanding, waiting for psdone
// ST_FINISH | done pulse, busy drops, back to idle
module mmcm_ps_ctrl
  import mmcm_ps_pkg::*;
#(
  parameter int STEP_W       = 16,
  parameter int POS_W        = 16,
  parameter int PERIOD_STEPS = DEF_PERIOD_STEPS,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic              psclk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic              pos_clr,
  input  logic              locked,
  output logic              psen,
  output logic              psincdec,
  input  logic              psdone,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_unlock,
  output logic [STEP_W-1:0] steps_left,
  output logic [POS_W-1:0]  phase_pos
);

  localparam int TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

  ps_state_e         state;
  logic [TCNT_W-1:0] tcnt;
  logic              accept;
  logic              step_ok;

  assign cmd_ready = (state == ST_IDLE) & locked;
  assign accept    = cmd_valid & cmd_ready;
  // psen is decoded from the state register so the MMCM never sees a pulse
  // in a cycle where lock is already gone, and reset kills it at once.
  assign psen      = (state == ST_ISSUE) & locked;
  assign step_ok   = (state == ST_WAIT) & locked & psdone;

  always_ff @(posedge psclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      psincdec    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_unlock  <= 1'b0;
      steps_left  <= '0;
      tcnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            steps_left  <= cmd_steps;
            psincdec    <= cmd_dir;
            err_timeout <= 1'b0;
            err_unlock  <= 1'b0;
            busy        <= 1'b1;
            if (cmd_steps == '0) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (locked) begin
            tcnt  <= '0;
            state <= ST_WAIT;
          end else begin
            err_unlock <= 1'b1;
            state      <= ST_FINISH;
            done       <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!locked) begin
            err_unlock <= 1'b1;
            state      <= ST_FINISH;
            done       <= 1'b1;
          end else if (psdone) begin
            steps_left <= steps_left - STEP_W'(1);
            if (steps_left == STEP_W'(1)) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state <= ST_ISSUE;
            end
          end else if (tcnt == TCNT_LAST) begin
            err_timeout <= 1'b1;
            state       <= ST_FINISH;
            done        <= 1'b1;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ps_pos_counter #(
    .POS_W       (POS_W),
    .PERIOD_STEPS(PERIOD_STEPS)
  ) u_pos (
    .psclk  (psclk),
    .reset_n(reset_n),
    .clr    (pos_clr & (state == ST_IDLE)),
    .step_en(step_ok),
    .up     (psincdec),
    .pos    (phase_pos)
  );

endmodule
